complete_arbiter: RTL and testbench
===================================

# complete_arbiter

Complete-stage arbiter between the functional units (ALU, fu_mult, branch, load) and the CDB. Each cycle it collects FU_COMPLETE_PACKETs from FUs asserting want_to_complete and grants up to CDB_W of them round-robin. Granted packets are registered onto the CDB broadcast slots. Each losing FU receives complete_stall and must hold its packet.

## Interface
- NUM_FU, 4: number of FU complete ports.
- CDB_W, 2: CDB broadcast slots per cycle; 1 ≤ CDB_W ≤ NUM_FU.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- squash  in  1  synchronous flush from ROB (mispredict/exception).
- fu_want  in  NUM_FU  want_to_complete from each FU.
- fu_packet_in  in  FU_COMPLETE_PACKET[NUM_FU]  completing packet per FU.
- fu_stall  out  NUM_FU  complete_stall to each FU (combinational).
- cdb_packet_out  out  FU_COMPLETE_PACKET[CDB_W]  registered broadcast slots.

## Operation
- Request vector: req[i] = fu_want[i] & fu_packet_in[i].valid.
- State:
  - rr_ptr, log2(NUM_FU) bits: the highest-priority FU index.
  - cdb_packet_out registers.
- Selection:
  - Scan i = rr_ptr, rr_ptr+1, … mod NUM_FU.
  - The first CDB_W requesters are granted in scan order.
  - The k-th grant goes to slot k; slot 0 is always filled first.
- Stall:
  - fu_stall[i] = req[i] & ~grant[i].
  - fu_stall[i] is 0 for every non-requesting FU.
- Pointer update, only on a clock edge with at least one grant: rr_ptr <= (index of last granted FU + 1) mod NUM_FU.
- With no grant, rr_ptr holds.
- Output register:
  - Granted slots load the corresponding fu_packet_in unmodified, including halt, if_take_branch, target_pc, dest_pr, dest_value and rob_entry.
  - Ungranted slots load all-zero; valid = 0.
- squash = 1:
  - grant = 0 and fu_stall = 0 in that cycle; the FUs flush themselves.
  - cdb_packet_out loads all-zero on the edge.
  - rr_ptr holds.
- halt packets get no special priority; they are arbitrated like any other packet.
- Packets are never duplicated or dropped:
  - A stalled FU presents the same packet next cycle.
  - The arbiter keeps no copy of a stalled packet.

## Timing
- Reset (reset = 0, asynchronous):
  - cdb_packet_out all zero (valid = 0) immediately, independent of clock.
  - rr_ptr = 0.
  - fu_stall = 0, since no packet valid is sampled as granted during reset.
- Latency: a packet granted in cycle N appears on cdb_packet_out in cycle N+1 after the rising edge.
- fu_stall is a same-cycle combinational function of fu_want, fu_packet_in.valid, rr_ptr and squash.
  - An FU sampling complete_stall at the edge therefore holds correctly.
- Requests ≤ CDB_W: all are granted and no stall is asserted.
- Requests > CDB_W: exactly CDB_W grants and (requests − CDB_W) stalls.
- Starvation bound: a continuously requesting FU is granted within ceil(NUM_FU/CDB_W) cycles.
- Wrap-around: the scan and rr_ptr increment modulo NUM_FU. A pointer at NUM_FU−1 with a grant there moves to 0.
- Reset released mid-burst: the first edge after release arbitrates from rr_ptr = 0.

## Test plan
- Reset: hold reset = 0 for 2 cycles with fu_want = 4'b1111 → cdb_packet_out[0..1].valid = 0, fu_stall = 0, rr_ptr = 0; release at negedge.
- Single requester:
  - Stimulus: FU2 presents valid, dest_pr = 32, rob_entry = 6, dest_value = 32'he0e1e1e2.
  - Same cycle: fu_stall = 0.
  - Next cycle: slot 0 carries the packet; slot 1 has valid = 0.
  - Following cycle, with fu_want = 0: both slots invalid.
- Oversubscription from rr_ptr = 0:
  - Cycle N: all four FUs request → grant FU0 (slot 0) and FU1 (slot 1), fu_stall = 4'b1100.
  - Cycle N+1: with FU2/FU3 still requesting, grant FU2 (slot 0) and FU3 (slot 1), fu_stall = 0.
  - Afterwards: rr_ptr = 0.
- Wrap-around:
  - Stimulus: rr_ptr = 3; FU3, FU0 and FU1 request.
  - Response: slot 0 = FU3, slot 1 = FU0, fu_stall = 4'b0010, rr_ptr → 1.
  - Next cycle: FU1 is granted in slot 0.
- Squash: assert squash with FU0 and FU1 requesting → fu_stall = 0; next cycle both slots have valid = 0 and rr_ptr is unchanged.
- Async reset mid-operation:
  - Stimulus: a slot holds a valid packet; drive reset = 0 at clock-high + 1 ns.
  - Response: cdb_packet_out.valid drops before the next edge, and rr_ptr reads 0 after release.

Source files
------------

// File: rtl/complete_arbiter.sv
// complete_arbiter
//   Complete-stage arbiter between the functional units and the CDB.
//   Each cycle it takes the FUs whose want_to_complete and packet valid are
//   both set, and grants up to CDB_W of them round-robin starting at rr_ptr.
//   Granted packets are registered onto the CDB slots. Losing FUs see
//   fu_stall and hold their packet.
//
// Ports
//   clock_i          system clock, rising edge
//   reset_i          asynchronous active-low reset
//   squash_i         synchronous flush: no grants, no stalls, CDB cleared
//   fu_want_i        want_to_complete per FU
//   fu_packet_in_i   completing packet per FU
//   fu_stall_o       combinational complete_stall per FU
//   cdb_packet_out_o registered CDB broadcast slots (slot 0 filled first)

package complete_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic        halt;
    logic        if_take_branch;
    logic [31:0] target_pc;
    logic [5:0]  dest_pr;
    logic [31:0] dest_value;
    logic [4:0]  rob_entry;
  } fu_complete_packet_t;
endpackage

// One CDB slot register: loads the selected packet when granted, else zero.
module complete_arbiter_slot
  import complete_arbiter_pkg::*;
(
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  fu_complete_packet_t pkt_i,
  output fu_complete_packet_t pkt_o
);
  fu_complete_packet_t pkt_q, pkt_d;

  assign pkt_d = load_i ? pkt_i : '0;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) pkt_q <= '0;
    else          pkt_q <= pkt_d;
  end

  assign pkt_o = pkt_q;
endmodule

module complete_arbiter
  import complete_arbiter_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int CDB_W  = 2
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic                                squash_i,
  input  logic                [NUM_FU-1:0]    fu_want_i,
  input  fu_complete_packet_t [NUM_FU-1:0]    fu_packet_in_i,
  output logic                [NUM_FU-1:0]    fu_stall_o,
  output fu_complete_packet_t [CDB_W-1:0]     cdb_packet_out_o
);
  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int RW = $clog2(NUM_FU + 1);

  logic [PW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0]          req, grant;
  logic                       arb_en;
  logic [NUM_FU-1:0][PW-1:0]  rot_idx;   // FU index at scan position
  logic [NUM_FU-1:0]          rot_req;
  logic [NUM_FU-1:0][RW-1:0]  rot_rank;  // requesters ahead in scan order
  logic [CDB_W-1:0][PW-1:0]   slot_sel;
  logic [CDB_W-1:0]           slot_vld;
  fu_complete_packet_t [CDB_W-1:0] slot_pkt;

  // Nothing is granted while in reset or squashing, so no stall either.
  assign arb_en = reset_i & ~squash_i;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) req[i] = fu_want_i[i] & fu_packet_in_i[i].valid;
  end

  // Rotate the request vector so scan position 0 is rr_ptr, then rank each
  // requester by how many requesters precede it. Rank < CDB_W wins, and the
  // rank is also the slot it lands in.
  always_comb begin
    logic [RW-1:0] cnt;
    logic [PW-1:0] last;
    logic          any;
    cnt      = '0;
    last     = rr_ptr_q;
    any      = 1'b0;
    grant    = '0;
    rot_idx  = '0;
    rot_req  = '0;
    rot_rank = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      rot_idx[off]  = PW'((int'(rr_ptr_q) + off) % NUM_FU);
      rot_req[off]  = req[rot_idx[off]] & arb_en;
      rot_rank[off] = cnt;
      if (rot_req[off]) cnt = cnt + RW'(1);
      if (rot_req[off] && rot_rank[off] < RW'(CDB_W)) begin
        grant[rot_idx[off]] = 1'b1;
        last                = rot_idx[off];
        any                 = 1'b1;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (any) rr_ptr_d = (last == PW'(NUM_FU - 1)) ? '0 : last + PW'(1);
  end

  always_comb begin
    slot_sel = '0;
    slot_vld = '0;
    for (int k = 0; k < CDB_W; k++) begin
      for (int off = 0; off < NUM_FU; off++) begin
        if (rot_req[off] && rot_rank[off] == RW'(k)) begin
          slot_sel[k] = rot_idx[off];
          slot_vld[k] = 1'b1;
        end
      end
      slot_pkt[k] = fu_packet_in_i[slot_sel[k]];
    end
  end

  assign fu_stall_o = req & ~grant & {NUM_FU{arb_en}};

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end

  for (genvar k = 0; k < CDB_W; k++) begin : g_slot
    complete_arbiter_slot u_slot (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .load_i  (slot_vld[k]),
      .pkt_i   (slot_pkt[k]),
      .pkt_o   (cdb_packet_out_o[k])
    );
  end
endmodule

// File: tb/tb_complete_arbiter.sv
module tb_complete_arbiter;
  import complete_arbiter_pkg::*;
  typedef fu_complete_packet_t pkt_t;
  typedef pkt_t [1:0] cdb_t;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       squash  = 1'b0;
  logic [3:0] want    = '0;
  pkt_t [3:0] pin;
  logic [3:0] stall;
  cdb_t       cdb;

  int   checks = 0;
  int   errors = 0;
  cdb_t exp_q[$];
  pkt_t P0, P1, P2, P3, Z;

  always #5 clock = ~clock;

  complete_arbiter #(.NUM_FU(4), .CDB_W(2)) dut (
    .clock_i          (clock),
    .reset_i          (reset_n),
    .squash_i         (squash),
    .fu_want_i        (want),
    .fu_packet_in_i   (pin),
    .fu_stall_o       (stall),
    .cdb_packet_out_o (cdb)
  );

  task automatic chk_stall(input string name, input logic [3:0] exp);
    checks++;
    if (stall !== exp) begin
      errors++;
      $display("FAIL %s: fu_stall got %b expected %b", name, stall, exp);
    end
  endtask

  task automatic chk_cdb_idle(input string name);
    checks++;
    if (cdb[0].valid !== 1'b0 || cdb[1].valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: cdb valid got %b%b expected 00", name, cdb[1].valid, cdb[0].valid);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, check the same-cycle
  // stall, and queue the CDB contents expected after the next rising edge.
  task automatic step(input string name, input logic [3:0] w, input logic sq,
                      input logic [3:0] exp_stall, input pkt_t e0, input pkt_t e1);
    cdb_t e;
    @(negedge clock);
    want   = w;
    squash = sq;
    #1;
    chk_stall(name, exp_stall);
    e[0] = e0;
    e[1] = e1;
    exp_q.push_back(e);
  endtask

  // Monitor: after every rising edge, compare the CDB against the oldest
  // expectation; with nothing queued the CDB must be idle.
  always @(posedge clock) begin
    cdb_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (cdb !== e) begin
        errors++;
        $display("FAIL cdb: got %h expected %h", cdb, e);
      end
    end else if (reset_n && (cdb[0].valid || cdb[1].valid)) begin
      checks++;
      errors++;
      $display("FAIL cdb_unexpected: got %h expected idle", cdb);
    end
  end

  initial begin
    Z  = '0;
    P0 = '{valid:1'b1, halt:1'b1, if_take_branch:1'b0, target_pc:32'h0000_1000,
           dest_pr:6'd10, dest_value:32'hA000_0000, rob_entry:5'd1};
    P1 = '{valid:1'b1, halt:1'b0, if_take_branch:1'b1, target_pc:32'h0000_2004,
           dest_pr:6'd11, dest_value:32'hA000_0011, rob_entry:5'd2};
    P2 = '{valid:1'b1, halt:1'b0, if_take_branch:1'b0, target_pc:32'h0000_3008,
           dest_pr:6'd32, dest_value:32'he0e1e1e2, rob_entry:5'd6};
    P3 = '{valid:1'b1, halt:1'b0, if_take_branch:1'b1, target_pc:32'hFFFF_FFFC,
           dest_pr:6'd63, dest_value:32'h5555_AAAA, rob_entry:5'd31};
    pin[0] = P0; pin[1] = P1; pin[2] = P2; pin[3] = P3;

    // Reset held with every FU requesting.
    want = 4'b1111;
    #3;
    chk_stall("rst_stall_a", 4'b0000);
    chk_cdb_idle("rst_cdb_a");
    @(posedge clock); @(posedge clock); #1;
    chk_stall("rst_stall_b", 4'b0000);
    chk_cdb_idle("rst_cdb_b");
    @(negedge clock);
    want    = '0;
    reset_n = 1'b1;

    step("single",  4'b0100, 1'b0, 4'b0000, P2, Z);   // ptr -> 3
    step("idle",    4'b0000, 1'b0, 4'b0000, Z,  Z);
    step("fu3",     4'b1000, 1'b0, 4'b0000, P3, Z);   // ptr -> 0
    step("over_a",  4'b1111, 1'b0, 4'b1100, P0, P1);  // ptr -> 2
    step("over_b",  4'b1100, 1'b0, 4'b0000, P2, P3);  // ptr -> 0
    step("over_c",  4'b1111, 1'b0, 4'b1100, P0, P1);  // ptr back at 0 before this
    step("to3",     4'b0100, 1'b0, 4'b0000, P2, Z);   // ptr -> 3
    step("wrap_a",  4'b1011, 1'b0, 4'b0010, P3, P0);  // ptr -> 1
    step("wrap_b",  4'b0010, 1'b0, 4'b0000, P1, Z);   // ptr -> 2
    step("squash",  4'b0111, 1'b1, 4'b0000, Z,  Z);   // ptr holds at 2
    step("post_sq", 4'b1111, 1'b0, 4'b0011, P2, P3);  // ptr -> 0

    // Async reset while both slots hold valid packets.
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk_cdb_idle("async_rst_cdb");
    chk_stall("async_rst_stall", 4'b0000);
    @(negedge clock);
    want = '0;
    @(negedge clock);
    reset_n = 1'b1;

    step("post_rst", 4'b1111, 1'b0, 4'b1100, P0, P1);
    step("final",    4'b0000, 1'b0, 4'b0000, Z,  Z);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
